// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: memory-mapped 8N1 UART transmitter on the data-memory store path.
// Stores to TXDATA are queued in a FIFO and serialised on txd. STATUS is a registered
// read word that software polls before writing.
// Build option: define UART_TX_PARITY_EN for even parity (8E1, 11-bit frame).
//
//   state    | meaning
//   S_IDLE   | line high, pop the next byte when the FIFO holds one
//   S_START  | start bit (low) for CLK_DIV cycles
//   S_DATA   | eight data bits, LSB first
//   S_PARITY | even parity bit (parity build only)
//   S_STOP   | stop bit (high) for CLK_DIV cycles
module uart_tx_mmio #(
  parameter logic [31:0] BASE_ADDR  = 32'hFFFF_0000,
  parameter int          CLK_DIV    = 434,
  parameter int          FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] addr,
  input  logic        wren,
  input  logic [31:0] wdata,
  input  logic [3:0]  byteen,
  output logic [31:0] rdata,
  output logic        txd,
  output logic        irq
);

  localparam int          AW          = $clog2(FIFO_DEPTH);
  localparam logic [31:0] STAT_ADDR   = BASE_ADDR + 32'd4;
  localparam logic [15:0] BAUD_RELOAD = 16'(CLK_DIV - 1);
  localparam logic [AW:0] FULL_CNT    = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_t;

  state_t      r_state;
  logic [7:0]  r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0] r_count;
  logic        r_ovf;
  logic [7:0]  r_shift;
  logic [2:0]  r_bitidx;
  logic [15:0] r_baud;
  logic        r_txd;
  logic        r_irq;
  logic [31:0] r_rdata;

  state_t      w_state_nxt;
  logic [7:0]  w_shift_nxt;
  logic [2:0]  w_bitidx_nxt;
  logic [15:0] w_baud_nxt;
  logic        w_txd_nxt;
  logic        w_pop;
  logic        w_sel_data, w_sel_stat, w_wr_data, w_push;
  logic        w_full, w_empty, w_busy, w_bit_end;
  logic        w_ovf_set, w_ovf_clr;
  logic [31:0] w_status;
  logic        w_unused_ok;

  // Address decode ignores the byte offset; only lane 0 qualifies a register write.
  assign w_sel_data = (addr[31:2] == BASE_ADDR[31:2]);
  assign w_sel_stat = (addr[31:2] == STAT_ADDR[31:2]);
  assign w_wr_data  = w_sel_data & wren & byteen[0];
  assign w_full     = (r_count == FULL_CNT);
  assign w_empty    = (r_count == '0);
  assign w_push     = w_wr_data & ~w_full;
  assign w_ovf_set  = w_wr_data & w_full;
  assign w_ovf_clr  = w_sel_stat & wren & byteen[0] & wdata[3];
  assign w_busy     = (r_state != S_IDLE);
  assign w_bit_end  = (r_baud == 16'd0);
  assign w_status   = {16'h0, 8'(r_count), 4'h0, r_ovf, w_busy, w_empty, w_full};
  assign w_unused_ok = ^{addr[1:0], wdata[31:8], wdata[7:4], wdata[2:0], byteen[3:1]};

  assign rdata = r_rdata;
  assign txd   = r_txd;
  assign irq   = r_irq;

  // Transmit FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state, shifter, baud and line-level decisions. The shifter rotates rather than
  // discards, so after the last data bit it still holds all eight bits for parity.
  always_comb begin
    w_state_nxt  = r_state;
    w_shift_nxt  = r_shift;
    w_bitidx_nxt = r_bitidx;
    w_baud_nxt   = w_bit_end ? BAUD_RELOAD : r_baud - 16'd1;
    w_txd_nxt    = r_txd;
    w_pop        = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_txd_nxt = 1'b1;
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_shift_nxt = r_mem[r_rptr];
          w_baud_nxt  = BAUD_RELOAD;
          w_state_nxt = S_START;
          w_txd_nxt   = 1'b0;
        end
      end
      S_START: if (w_bit_end) begin
        w_state_nxt  = S_DATA;
        w_bitidx_nxt = 3'd0;
        w_txd_nxt    = r_shift[0];
      end
      S_DATA: if (w_bit_end) begin
        if (r_bitidx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
          w_state_nxt = S_PARITY;
          w_txd_nxt   = ^r_shift;
`else
          w_state_nxt = S_STOP;
          w_txd_nxt   = 1'b1;
`endif
        end else begin
          w_shift_nxt  = {r_shift[0], r_shift[7:1]};
          w_bitidx_nxt = r_bitidx + 3'd1;
          w_txd_nxt    = r_shift[1];
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: if (w_bit_end) begin
        w_state_nxt = S_STOP;
        w_txd_nxt   = 1'b1;
      end
`endif
      S_STOP: if (w_bit_end) begin
        w_state_nxt = S_IDLE;
        w_txd_nxt   = 1'b1;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_txd_nxt   = 1'b1;
      end
    endcase
  end

  // FIFO storage; contents need no reset because the count gates every read.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= wdata[7:0];
  end

  // Datapath, FIFO pointers, sticky overflow and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
      r_shift  <= 8'h00;
      r_bitidx <= 3'd0;
      r_baud   <= 16'd0;
      r_txd    <= 1'b1;
      r_irq    <= 1'b1;
      r_rdata  <= 32'h0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_ovf_set)      r_ovf <= 1'b1;
      else if (w_ovf_clr) r_ovf <= 1'b0;
      r_shift  <= w_shift_nxt;
      r_bitidx <= w_bitidx_nxt;
      r_baud   <= w_baud_nxt;
      r_txd    <= w_txd_nxt;
      r_irq    <= w_empty & (r_state == S_IDLE);
      r_rdata  <= w_sel_stat ? w_status : 32'h0;
    end
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed bench for uart_tx_mmio with CLK_DIV=4, FIFO_DEPTH=4. Inputs change on the
// falling edge, outputs are sampled on the falling edge. A small line receiver decodes
// txd independently so queued bytes can be checked without cycle-exact alignment.
module tb_uart_tx_mmio;
  localparam logic [31:0] BASE = 32'hFFFF_0000;
  localparam logic [31:0] STAT = 32'hFFFF_0004;
  localparam logic [31:0] UNMAP = 32'hFFFF_0008;
  localparam int CDIV = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [31:0] addr = 32'h0;
  logic        wren = 1'b0;
  logic [31:0] wdata = 32'h0;
  logic [3:0]  byteen = 4'h0;
  logic [31:0] rdata;
  logic        txd, irq;

  int n_tests = 0;
  int n_fail  = 0;

  logic       rx_busy = 1'b0;
  int         rx_cnt = 0;
  int         rx_k = 0;
  int         rx_err = 0;
  int         rx_lows = 0;
  logic [7:0] rx_byte = 8'h00;
  logic [7:0] rx_q[$];

  uart_tx_mmio #(.BASE_ADDR(BASE), .CLK_DIV(CDIV), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset_n(reset_n), .addr(addr), .wren(wren), .wdata(wdata),
    .byteen(byteen), .rdata(rdata), .txd(txd), .irq(irq)
  );

  always #5 clk = ~clk;

  // Line receiver: samples each bit in the middle of its CLK_DIV window.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        rx_busy = 1'b0;
      end else begin
        if (txd === 1'b0) rx_lows++;
        if (!rx_busy) begin
          if (txd === 1'b0) begin
            rx_busy = 1'b1;
            rx_cnt = 0;
          end
        end else begin
          rx_cnt++;
          if (rx_cnt % CDIV == CDIV / 2) begin
            rx_k = rx_cnt / CDIV;
            if (rx_k == 0) begin
              if (txd !== 1'b0) rx_err++;
            end else if (rx_k == NBITS - 1) begin
              if (txd !== 1'b1) rx_err++;
              rx_q.push_back(rx_byte);
              rx_busy = 1'b0;
            end else if (rx_k <= 8) begin
              rx_byte[rx_k-1] = txd;
            end else begin
              if (txd !== ^rx_byte) rx_err++;
            end
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got hang, required completion");
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] be, input logic we);
    @(negedge clk);
    addr = a; wdata = d; byteen = be; wren = we;
  endtask

  task automatic idle();
    drive(32'h0, 32'h0, 4'h0, 1'b0);
  endtask

  task automatic read_reg(input logic [31:0] a, output logic [31:0] v);
    drive(a, 32'h0, 4'h0, 1'b0);
    @(negedge clk);
    v = rdata;
  endtask

  // Checks every sample of one frame starting at the current falling edge (first start
  // sample) and returns on the falling edge just after the last stop cycle.
  task automatic check_frame(input logic [7:0] b);
    logic exp_bits [0:10];
    exp_bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) exp_bits[i+1] = b[i];
    if (NBITS == 11) exp_bits[9] = ^b;
    exp_bits[NBITS-1] = 1'b1;
    for (int bi = 0; bi < NBITS; bi++) begin
      for (int c = 0; c < CDIV; c++) begin
        n_tests++;
        if (txd !== exp_bits[bi]) begin
          n_fail++;
          $display("FAIL frame_%02h bit %0d cycle %0d: txd=%b required %b", b, bi, c, txd, exp_bits[bi]);
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_reset();
    logic [31:0] v;
    #2 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if (irq !== 1'b1 || txd !== 1'b1 || rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_first_clk: irq=%b txd=%b rdata=%h required 1 1 00000000", irq, txd, rdata);
    end
    repeat (10) @(negedge clk);
    n_tests++;
    if (txd !== 1'b1 || irq !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_idle: txd=%b irq=%b required 1 1", txd, irq);
    end
    read_reg(STAT, v);
    n_tests++;
    if (v !== 32'h0000_0002) begin
      n_fail++;
      $display("FAIL reset_status: got %h required 00000002", v);
    end
  endtask

  task automatic test_single_byte();
    logic [31:0] v;
    rx_q.delete();
    drive(BASE, 32'h0000_00A5, 4'b0001, 1'b1);
    idle();
    n_tests++;
    if (txd !== 1'b1) begin
      n_fail++;
      $display("FAIL single_before_pop: txd=%b required 1", txd);
    end
    @(negedge clk);
    n_tests++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL single_irq_busy: irq=%b required 0", irq);
    end
    check_frame(8'hA5);
    repeat (3) @(negedge clk);
    read_reg(STAT, v);
    n_tests++;
    if (v !== 32'h0000_0002 || irq !== 1'b1) begin
      n_fail++;
      $display("FAIL single_after: status=%h irq=%b required 00000002 1", v, irq);
    end
    n_tests++;
    if (rx_q.size() != 1 || rx_err != 0) begin
      n_fail++;
      $display("FAIL single_rx: got %0d bytes, %0d errors, required 1 byte 0 errors", rx_q.size(), rx_err);
    end else if (rx_q[0] !== 8'hA5) begin
      n_fail++;
      $display("FAIL single_rx_byte: got %h required a5", rx_q[0]);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] v;
    int t;
    rx_q.delete();
    rx_err = 0;
    for (int i = 1; i <= 6; i++) drive(BASE, 32'(i), 4'b0001, 1'b1);
    read_reg(STAT, v);
    n_tests++;
    if (v !== 32'h0000_040D) begin
      n_fail++;
      $display("FAIL ovf_status: got %h required 0000040d", v);
    end
    drive(STAT, 32'h8, 4'b0010, 1'b1);
    read_reg(STAT, v);
    n_tests++;
    if (v !== 32'h0000_040D) begin
      n_fail++;
      $display("FAIL ovf_clear_wrong_lane: got %h required 0000040d", v);
    end
    drive(STAT, 32'h8, 4'b0001, 1'b1);
    read_reg(STAT, v);
    n_tests++;
    if (v !== 32'h0000_0405) begin
      n_fail++;
      $display("FAIL ovf_clear: got %h required 00000405", v);
    end
    t = 0;
    while (rx_q.size() < 5 && t < 600) begin
      @(negedge clk);
      t++;
    end
    repeat (60) @(negedge clk);
    n_tests++;
    if (rx_q.size() != 5 || rx_err != 0) begin
      n_fail++;
      $display("FAIL ovf_rx_count: got %0d bytes, %0d errors, required 5 bytes 0 errors", rx_q.size(), rx_err);
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_tests++;
        if (rx_q[i] !== 8'(i + 1)) begin
          n_fail++;
          $display("FAIL ovf_rx_byte%0d: got %h required %h", i, rx_q[i], 8'(i + 1));
        end
      end
    end
    read_reg(STAT, v);
    n_tests++;
    if (v !== 32'h0000_0002) begin
      n_fail++;
      $display("FAIL ovf_final_status: got %h required 00000002", v);
    end
  endtask

  task automatic test_lanes();
    logic [31:0] v;
    int lows0;
    rx_q.delete();
    lows0 = rx_lows;
    drive(BASE, 32'h55, 4'b0010, 1'b1);
    read_reg(STAT, v);
    n_tests++;
    if (v !== 32'h0000_0002) begin
      n_fail++;
      $display("FAIL lane_ignored: status=%h required 00000002", v);
    end
    drive(UNMAP, 32'h77, 4'b1111, 1'b1);
    read_reg(STAT, v);
    n_tests++;
    if (v !== 32'h0000_0002) begin
      n_fail++;
      $display("FAIL unmapped_write: status=%h required 00000002", v);
    end
    read_reg(UNMAP, v);
    n_tests++;
    if (v !== 32'h0) begin
      n_fail++;
      $display("FAIL unmapped_read: got %h required 00000000", v);
    end
    read_reg(STAT, v);
    read_reg(BASE, v);
    n_tests++;
    if (v !== 32'h0) begin
      n_fail++;
      $display("FAIL txdata_read: got %h required 00000000", v);
    end
    repeat (60) @(negedge clk);
    n_tests++;
    if (rx_q.size() != 0 || rx_lows != lows0 || irq !== 1'b1) begin
      n_fail++;
      $display("FAIL lane_no_tx: bytes=%0d lows=%0d irq=%b required 0 0 1", rx_q.size(), rx_lows - lows0, irq);
    end
  endtask

  task automatic test_reset_midframe();
    logic [31:0] v;
    int lows0;
    rx_q.delete();
    drive(BASE, 32'h00, 4'b0001, 1'b1);
    drive(BASE, 32'h11, 4'b0001, 1'b1);
    drive(BASE, 32'h22, 4'b0001, 1'b1);
    idle();
    repeat (16) @(negedge clk);
    n_tests++;
    if (txd !== 1'b0) begin
      n_fail++;
      $display("FAIL midframe_bit3: txd=%b required 0", txd);
    end
    reset_n = 1'b0;
    #1;
    n_tests++;
    if (txd !== 1'b1 || irq !== 1'b1) begin
      n_fail++;
      $display("FAIL midframe_async: txd=%b irq=%b required 1 1", txd, irq);
    end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    lows0 = rx_lows;
    read_reg(STAT, v);
    n_tests++;
    if (v !== 32'h0000_0002) begin
      n_fail++;
      $display("FAIL midframe_status: got %h required 00000002", v);
    end
    repeat (100) @(negedge clk);
    n_tests++;
    if (rx_q.size() != 0 || rx_lows != lows0 || txd !== 1'b1) begin
      n_fail++;
      $display("FAIL midframe_no_tx: bytes=%0d lows=%0d txd=%b required 0 0 1", rx_q.size(), rx_lows - lows0, txd);
    end
  endtask

  task automatic test_back_to_back();
    rx_q.delete();
    rx_err = 0;
    drive(BASE, 32'h3C, 4'b0001, 1'b1);
    drive(BASE, 32'hC3, 4'b0001, 1'b1);
    idle();
    check_frame(8'h3C);
    n_tests++;
    if (txd !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_gap: txd=%b required 1", txd);
    end
    @(negedge clk);
    check_frame(8'hC3);
    repeat (5) @(negedge clk);
    n_tests++;
    if (rx_q.size() != 2 || rx_err != 0 || irq !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_rx: bytes=%0d errors=%0d irq=%b required 2 0 1", rx_q.size(), rx_err, irq);
    end else if (rx_q[0] !== 8'h3C || rx_q[1] !== 8'hC3) begin
      n_fail++;
      $display("FAIL b2b_rx_bytes: got %h %h required 3c c3", rx_q[0], rx_q[1]);
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_overflow();
    test_lanes();
    test_reset_midframe();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
